// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit that produces one result bit per cycle.
// Divide-by-zero and signed divide overflow complete through a one-cycle fast path.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    input  logic [TAG_WIDTH-1:0]  rd_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [TAG_WIDTH-1:0]  rd_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER  = CW'(W - 1);
    localparam logic [W-1:0]  MIN_SIGNED = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state;
    logic [2:0]           op;
    logic [TAG_WIDTH-1:0] rd_q;
    logic [W-1:0]         a_mag, b_mag, quot, rem;
    logic [2*W-1:0]       prod;
    logic [CW-1:0]        count;
    logic                 neg_res, neg_rem;

    logic         a_signed, b_signed, a_neg, b_neg, fast;
    logic [W-1:0] a_mag_in, b_mag_in, fast_result;

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3_i)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010:  a_signed = 1'b1;
            default: ;
        endcase
        a_neg    = a_signed & rs1_i[W-1];
        b_neg    = b_signed & rs2_i[W-1];
        a_mag_in = a_neg ? -rs1_i : rs1_i;
        b_mag_in = b_neg ? -rs2_i : rs2_i;

        // Divide corner cases resolve at accept and never enter CALC.
        fast        = 1'b0;
        fast_result = '0;
        if (funct3_i[2]) begin
            if (rs2_i == '0) begin
                fast        = 1'b1;
                fast_result = funct3_i[1] ? rs1_i : '1;
            end else if (!funct3_i[0] && rs1_i == MIN_SIGNED && rs2_i == '1) begin
                fast        = 1'b1;
                fast_result = funct3_i[1] ? '0 : rs1_i;
            end
        end
    end

    logic [W:0]   mul_sum, part_rem;
    logic [W-1:0] div_diff;
    logic         div_ge;

    always_comb begin
        mul_sum  = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, a_mag} : '0);
        part_rem = {rem, quot[W-1]};
        div_ge   = part_rem >= {1'b0, b_mag};
        div_diff = part_rem[W-1:0] - b_mag;
    end

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quot_fix, rem_fix, fix_result;

    always_comb begin
        prod_fix = neg_res ? -prod : prod;
        quot_fix = neg_res ? -quot : quot;
        rem_fix  = neg_rem ? -rem  : rem;
        case (op)
            3'b000:                 fix_result = prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*W-1:W];
            3'b100, 3'b101:         fix_result = quot_fix;
            default:                fix_result = rem_fix;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op       <= '0;
            rd_q     <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            quot     <= '0;
            rem      <= '0;
            prod     <= '0;
            count    <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
            rd_o     <= '0;
        end else begin
            valid_o <= 1'b0;
            if (flush_i) begin
                state  <= IDLE;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        state <= IDLE;
                        if (start_i) begin
                            op      <= funct3_i;
                            rd_q    <= rd_i;
                            a_mag   <= a_mag_in;
                            b_mag   <= b_mag_in;
                            neg_res <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            count   <= '0;
                            prod    <= {{W{1'b0}}, b_mag_in};
                            quot    <= a_mag_in;
                            rem     <= '0;
                            if (fast) begin
                                result_o <= fast_result;
                                rd_o     <= rd_i;
                                valid_o  <= 1'b1;
                                state    <= DONE;
                            end else begin
                                busy_o <= 1'b1;
                                state  <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        count <= count + 1'b1;
                        if (op[2]) begin
                            rem  <= div_ge ? div_diff : part_rem[W-1:0];
                            quot <= {quot[W-2:0], div_ge};
                        end else begin
                            prod <= {mul_sum, prod[W-1:1]};
                        end
                        if (count == LAST_ITER) state <= FIX;
                    end
                    FIX: begin
                        result_o <= fix_result;
                        rd_o     <= rd_q;
                        busy_o   <= 1'b0;
                        valid_o  <= 1'b1;
                        state    <= DONE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at W=32: results, tags, latency in clock edges
// after the accept edge, busy/valid handshake, flush and asynchronous reset.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam int T = 5;
    localparam int NORMAL_EDGE = W + 1;  // valid seen after edge E(W+1)
    localparam int FAST_EDGE   = 0;      // valid seen after the accept edge E0

    logic         clk = 1'b0;
    logic         rst, start, flush;
    logic [2:0]   funct3;
    logic [W-1:0] rs1, rs2;
    logic [T-1:0] rd;
    logic         busy, valid;
    logic [W-1:0] result;
    logic [T-1:0] rd_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_WIDTH(W), .TAG_WIDTH(T)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .funct3_i (funct3),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .rd_i     (rd),
        .flush_i  (flush),
        .busy_o   (busy),
        .valid_o  (valid),
        .result_o (result),
        .rd_o     (rd_out)
    );

    // Called at the negedge right after the accept edge; returns at the negedge where valid is seen.
    task automatic wait_valid(output int edge_n, output int busy_cycles);
        edge_n      = 0;
        busy_cycles = 0;
        while (edge_n < 100) begin
            if (busy) busy_cycles++;
            if (valid) break;
            @(negedge clk);
            edge_n++;
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [T-1:0] tag, output int edge_n, output int busy_cycles);
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b; rd = tag;
        @(negedge clk);
        start = 1'b0;
        wait_valid(edge_n, busy_cycles);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (result !== '0)   begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        checks++; if (rd_out !== '0)   begin errors++; $display("FAIL reset_rd: got %h want 0", rd_out); end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        logic [2:0]   f_tab [5];
        logic [W-1:0] a_tab [5];
        logic [W-1:0] b_tab [5];
        logic [W-1:0] e_tab [5];
        int e, bc;
        f_tab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b000};
        a_tab = '{32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        b_tab = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        e_tab = '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001};
        for (int i = 0; i < 5; i++) begin
            run_op(f_tab[i], a_tab[i], b_tab[i], T'(i + 1), e, bc);
            checks++; if (result !== e_tab[i]) begin errors++; $display("FAIL mul_result[%0d]: got %h want %h", i, result, e_tab[i]); end
            checks++; if (rd_out !== T'(i + 1)) begin errors++; $display("FAIL mul_rd[%0d]: got %0d want %0d", i, rd_out, i + 1); end
            checks++; if (e !== NORMAL_EDGE) begin errors++; $display("FAIL mul_latency[%0d]: got %0d want %0d", i, e, NORMAL_EDGE); end
            checks++; if (bc !== W + 1) begin errors++; $display("FAIL mul_busy_cycles[%0d]: got %0d want %0d", i, bc, W + 1); end
            @(negedge clk);
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mul_valid_pulse[%0d]: got %b want 0", i, valid); end
        end
    endtask

    task automatic test_divide();
        logic [2:0]   f_tab [6];
        logic [W-1:0] a_tab [6];
        logic [W-1:0] b_tab [6];
        logic [W-1:0] e_tab [6];
        int e, bc;
        f_tab = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
        a_tab = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7};
        b_tab = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
        e_tab = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1};
        for (int i = 0; i < 6; i++) begin
            run_op(f_tab[i], a_tab[i], b_tab[i], T'(i + 10), e, bc);
            checks++; if (result !== e_tab[i]) begin errors++; $display("FAIL div_result[%0d]: got %h want %h", i, result, e_tab[i]); end
            checks++; if (rd_out !== T'(i + 10)) begin errors++; $display("FAIL div_rd[%0d]: got %0d want %0d", i, rd_out, i + 10); end
            checks++; if (e !== NORMAL_EDGE) begin errors++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, e, NORMAL_EDGE); end
        end
    endtask

    task automatic test_fast_path();
        logic [2:0]   f_tab [5];
        logic [W-1:0] a_tab [5];
        logic [W-1:0] b_tab [5];
        logic [W-1:0] e_tab [5];
        int e, bc;
        f_tab = '{3'b100, 3'b110, 3'b101, 3'b100, 3'b110};
        a_tab = '{32'd5, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
        b_tab = '{32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        e_tab = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h80000000, 32'd0};
        for (int i = 0; i < 5; i++) begin
            run_op(f_tab[i], a_tab[i], b_tab[i], T'(i + 20), e, bc);
            checks++; if (result !== e_tab[i]) begin errors++; $display("FAIL fast_result[%0d]: got %h want %h", i, result, e_tab[i]); end
            checks++; if (rd_out !== T'(i + 20)) begin errors++; $display("FAIL fast_rd[%0d]: got %0d want %0d", i, rd_out, i + 20); end
            checks++; if (e !== FAST_EDGE) begin errors++; $display("FAIL fast_latency[%0d]: got %0d want %0d", i, e, FAST_EDGE); end
            checks++; if (bc !== 0) begin errors++; $display("FAIL fast_busy[%0d]: got %0d busy cycles want 0", i, bc); end
        end
    endtask

    task automatic test_busy_ignore();
        int e = 0;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; rd = 5'd6;
        @(negedge clk);
        start = 1'b0;
        while (e < 100) begin
            if (valid) break;
            if (e == 5 || e == 20) begin
                start = 1'b1; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd3; rd = 5'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            e++;
        end
        start = 1'b0;
        checks++; if (result !== 32'd14) begin errors++; $display("FAIL busy_ignore_result: got %h want %h", result, 32'd14); end
        checks++; if (rd_out !== 5'd6) begin errors++; $display("FAIL busy_ignore_rd: got %0d want 6", rd_out); end
        checks++; if (e !== NORMAL_EDGE) begin errors++; $display("FAIL busy_ignore_latency: got %0d want %0d", e, NORMAL_EDGE); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL busy_ignore_queued: got busy=%b valid=%b want 0/0", busy, valid); end
    endtask

    task automatic test_back_to_back();
        int e, bc;
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, e, bc);
        checks++; if (result !== 32'hFFFFFFFE) begin errors++; $display("FAIL b2b_first_result: got %h want FFFFFFFE", result); end
        // Still in the DONE cycle: request the next op so it is accepted from DONE.
        start = 1'b1; funct3 = 3'b100; rs1 = 32'hFFFFFFF9; rs2 = 32'd2; rd = 5'd8;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
        wait_valid(e, bc);
        checks++; if (e !== NORMAL_EDGE) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", e, NORMAL_EDGE); end
        checks++; if (result !== 32'hFFFFFFFD) begin errors++; $display("FAIL b2b_second_result: got %h want FFFFFFFD", result); end
        checks++; if (rd_out !== 5'd8) begin errors++; $display("FAIL b2b_second_rd: got %0d want 8", rd_out); end
    endtask

    task automatic test_flush();
        int seen = 0;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd7; rs2 = 32'd9; rd = 5'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
        for (int i = 0; i < 40; i++) begin
            if (valid) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_valid: got %0d valid cycles want 0", seen); end
        checks++; if (result !== 32'hFFFFFFFD) begin errors++; $display("FAIL flush_result_kept: got %h want FFFFFFFD", result); end
        checks++; if (rd_out !== 5'd8) begin errors++; $display("FAIL flush_rd_kept: got %0d want 8", rd_out); end
    endtask

    task automatic test_flush_start();
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'b100; rs1 = 32'd5; rs2 = 32'd0; rd = 5'd11;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_start_accepted: got valid=%b busy=%b want 0/0", valid, busy); end
        @(negedge clk);
        checks++; if (result !== 32'hFFFFFFFD || rd_out !== 5'd8) begin errors++; $display("FAIL flush_start_outputs: got %h/%0d want FFFFFFFD/8", result, rd_out); end
    endtask

    task automatic test_async_reset();
        int e, bc;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b011; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF; rd = 5'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_mid_calc: got busy=%b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", valid); end
        checks++; if (result !== '0)  begin errors++; $display("FAIL areset_result: got %h want 0", result); end
        checks++; if (rd_out !== '0)  begin errors++; $display("FAIL areset_rd: got %0d want 0", rd_out); end
        @(negedge clk);
        rst = 1'b0;
        run_op(3'b101, 32'd100, 32'd7, 5'd12, e, bc);
        checks++; if (result !== 32'd14) begin errors++; $display("FAIL areset_after_result: got %h want %h", result, 32'd14); end
        checks++; if (rd_out !== 5'd12) begin errors++; $display("FAIL areset_after_rd: got %0d want 12", rd_out); end
        checks++; if (e !== NORMAL_EDGE) begin errors++; $display("FAIL areset_after_latency: got %0d want %0d", e, NORMAL_EDGE); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = '0; rs1 = '0; rs2 = '0; rd = '0;
        test_reset();
        test_mul();
        test_divide();
        test_fast_path();
        test_busy_ignore();
        test_back_to_back();
        test_flush();
        test_flush_start();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
